// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants, FSM encoding and write-strobe helper for the sram-like to AXI3 bridge.
package sram_axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         ID_INST    = 0;
    localparam int         ID_DATA    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_WR_RESP
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    wstrb_of = 4'b0001 << addr_lo;
            2'd1:    wstrb_of = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: wstrb_of = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_axi_arbiter.sv
// Fixed-priority grant (data over inst), addr_ok generation and request latches.
module sram_axi_arbiter
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  idle,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [1:0]            inst_size,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  inst_addr_ok,
    output logic                  data_addr_ok,
    output logic                  grant,
    output logic                  grant_wr,
    output logic [ADDR_WIDTH-1:0] lat_addr,
    output logic [1:0]            lat_size,
    output logic                  lat_wr,
    output logic [31:0]           lat_wdata,
    output owner_t                lat_owner
);

    // Gating with resetn keeps both addr_ok low while reset is asserted.
    assign data_addr_ok = resetn & idle & data_req;
    assign inst_addr_ok = resetn & idle & inst_req & ~data_req;
    assign grant        = data_addr_ok | inst_addr_ok;
    assign grant_wr     = data_addr_ok & data_wr;

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: request latches are plain registers, so they get an explicit reset value.
        if (!resetn) begin
            lat_addr  <= '0;
            lat_size  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_owner <= OWN_INST;
        end else if (data_addr_ok) begin
            // NOTE: sequential state uses non-blocking assignments only.
            lat_addr  <= data_addr;
            lat_size  <= data_size;
            lat_wr    <= data_wr;
            lat_wdata <= data_wdata;
            lat_owner <= OWN_DATA;
        end else if (inst_addr_ok) begin
            lat_addr  <= inst_addr;
            lat_size  <= inst_size;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_owner <= OWN_INST;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Two sram-like masters (inst read-only, data read/write) onto one single-beat AXI3 master, one transaction in flight.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [1:0]            inst_size,
    output logic [31:0]           inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic [31:0]           data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_WIDTH-1:0]   wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    state_t                state_q, state_d;
    logic                  aw_done_q, w_done_q;
    logic                  grant, grant_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_size;
    logic                  lat_wr;
    logic [31:0]           lat_wdata;
    owner_t                lat_owner;
    logic                  aw_hs, w_hs, rd_done;
    logic [ID_WIDTH-1:0]   owner_id;

    sram_axi_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) u_arbiter (
        .clk          (clk),
        .resetn       (resetn),
        .idle         (state_q == S_IDLE),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .inst_addr_ok (inst_addr_ok),
        .data_addr_ok (data_addr_ok),
        .grant        (grant),
        .grant_wr     (grant_wr),
        .lat_addr     (lat_addr),
        .lat_size     (lat_size),
        .lat_wr       (lat_wr),
        .lat_wdata    (lat_wdata),
        .lat_owner    (lat_owner)
    );

    // Response IDs and codes are not checked; one transaction is in flight at a time.
    logic unused_ok;
    assign unused_ok = &{1'b0, rid, rresp, bid, bresp, lat_wr};

    assign owner_id = (lat_owner == OWN_DATA) ? ID_WIDTH'(ID_DATA) : ID_WIDTH'(ID_INST);
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign rd_done  = (state_q == S_RD_DATA) & rvalid & rlast;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != S_WR) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                aw_done_q <= aw_done_q | aw_hs;
                w_done_q  <= w_done_q | w_hs;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        state_d      = state_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = grant_wr ? S_WR : S_RD_ADDR;
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready       = 1'b1;
                inst_data_ok = rd_done & (lat_owner == OWN_INST);
                data_data_ok = rd_done & (lat_owner == OWN_DATA);
                if (rd_done) state_d = S_IDLE;
            end
            S_WR: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if ((aw_done_q | (~aw_done_q & awready)) & (w_done_q | (~w_done_q & wready)))
                    state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready       = 1'b1;
                data_data_ok = bvalid;
                if (bvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    assign arid    = owner_id;
    assign araddr  = lat_addr;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, lat_size};
    assign arburst = BURST_INCR;

    assign awid    = owner_id;
    assign awaddr  = lat_addr;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, lat_size};
    assign awburst = BURST_INCR;

    assign wid     = owner_id;
    assign wdata   = lat_wdata;
    assign wstrb   = wstrb_of(lat_size, lat_addr[1:0]);
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench: the bench plays the AXI slave and both sram masters, with hand-computed expectations.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0]  inst_size;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_axi_bridge #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Starts just after a negedge with the bridge in RD_ADDR; returns just after a negedge in IDLE.
    task automatic axi_read(input int ar_delay, input logic [3:0] exp_id, input logic [31:0] exp_addr,
                            input logic [2:0] exp_size, input logic [31:0] rd, input logic is_data);
        for (int i = 0; i < ar_delay; i++) begin
            #1 check("arvalid_hold", {31'd0, arvalid}, 32'd1);
            @(negedge clk);
        end
        arready = 1'b1;
        #1;
        check("arvalid", {31'd0, arvalid}, 32'd1);
        check("arid", {28'd0, arid}, {28'd0, exp_id});
        check("araddr", araddr, exp_addr);
        check("arsize", {29'd0, arsize}, {29'd0, exp_size});
        check("arlen_burst", {26'd0, arlen, arburst}, {26'd0, 4'd0, 2'b01});
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = rd;
        #1;
        check("arvalid_drop", {31'd0, arvalid}, 32'd0);
        check("rready", {31'd0, rready}, 32'd1);
        check("data_ok_pair", {30'd0, inst_data_ok, data_data_ok}, is_data ? 32'd1 : 32'd2);
        check("rdata", is_data ? data_rdata : inst_rdata, rd);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1 check("data_ok_end", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    endtask

    // Starts just after a negedge with the bridge in WR; returns just after a negedge in IDLE.
    task automatic axi_write(input int aw_delay, input int w_delay, input logic [31:0] exp_addr,
                             input logic [2:0] exp_size, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_strb);
        int aw_hs = 0;
        int w_hs  = 0;
        int last  = (aw_delay > w_delay) ? aw_delay : w_delay;
        for (int cyc = 0; cyc <= last; cyc++) begin
            awready = (cyc == aw_delay);
            wready  = (cyc == w_delay);
            #1;
            check("awvalid_seq", {31'd0, awvalid}, (cyc <= aw_delay) ? 32'd1 : 32'd0);
            check("wvalid_seq", {31'd0, wvalid}, (cyc <= w_delay) ? 32'd1 : 32'd0);
            if (awvalid && awready) begin
                aw_hs++;
                check("aw_fields", awaddr, exp_addr);
                check("aw_ctl", {21'd0, awid, awlen, awsize, awburst}, {21'd0, 4'd1, 4'd0, exp_size, 2'b01});
            end
            if (wvalid && wready) begin
                w_hs++;
                check("wdata", wdata, exp_wdata);
                check("w_ctl", {23'd0, wid, wstrb, wlast}, {23'd0, 4'd1, exp_strb, 1'b1});
            end
            @(negedge clk);
        end
        awready = 1'b0;
        wready  = 1'b0;
        #1;
        check("hs_counts", {aw_hs[15:0], w_hs[15:0]}, {16'd1, 16'd1});
        check("wr_resp_state", {29'd0, awvalid, wvalid, bready}, 32'd1);
        check("no_ok_before_b", {31'd0, data_data_ok}, 32'd0);
        bvalid = 1'b1;
        #1 check("b_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
        #1 check("b_done", {30'd0, bready, data_data_ok}, 32'd0);
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_addr  = addr;
        data_size  = size;
        data_wdata = wd;
        #1 check("wr_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        @(negedge clk);
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_addr  = 32'hDEAD_BEEF;
        data_size  = 2'd3;
        data_wdata = 32'h5555_5555;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0; inst_size = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs",
                 {24'd0, arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, inst_data_ok | data_data_ok},
                 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // 1: inst read, arready after two cycles
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        inst_size = 2'd2;
        #1 check("t1_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        @(negedge clk);
        inst_req  = 1'b0;
        inst_addr = 32'h0;
        axi_read(2, 4'd0, 32'hBFC0_0000, 3'd2, 32'h3C1D_0001, 1'b0);

        // 2: simultaneous requests, data wins
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        inst_size = 2'd2;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h1000_0010;
        data_size = 2'd2;
        #1 check("t2_grant_data", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        @(negedge clk);
        data_req = 1'b0;
        #1 check("t2_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
        axi_read(0, 4'd1, 32'h1000_0010, 3'd2, 32'hCAFE_F00D, 1'b1);
        check("t2_inst_after", {31'd0, inst_addr_ok}, 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        axi_read(1, 4'd0, 32'h0000_0100, 3'd2, 32'h1234_5678, 1'b0);

        // 3: byte write to the top lane
        @(negedge clk);
        start_write(32'h8000_0003, 2'd0, 32'hAB00_0000);
        axi_write(1, 1, 32'h8000_0003, 3'd0, 32'hAB00_0000, 4'b1000);

        // 4: aw/w handshake orderings
        @(negedge clk);
        start_write(32'h0000_0040, 2'd2, 32'h0102_0304);
        axi_write(3, 0, 32'h0000_0040, 3'd2, 32'h0102_0304, 4'b1111);
        @(negedge clk);
        start_write(32'h0000_0045, 2'd0, 32'h0000_7700);
        axi_write(0, 3, 32'h0000_0045, 3'd0, 32'h0000_7700, 4'b0010);
        @(negedge clk);
        start_write(32'h0000_0050, 2'd1, 32'h0000_BEEF);
        axi_write(0, 0, 32'h0000_0050, 3'd1, 32'h0000_BEEF, 4'b0011);

        // 5: reset while arvalid is high
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1234;
        inst_size = 2'd2;
        #1 check("t5_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        @(negedge clk);
        #1 check("t5_arvalid", {31'd0, arvalid}, 32'd1);
        #2 resetn = 1'b0;
        #1 check("t5_abort", {27'd0, arvalid, rready, awvalid, wvalid, inst_addr_ok}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("t5_regrant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        @(negedge clk);
        inst_req = 1'b0;
        axi_read(0, 4'd0, 32'h0000_1234, 3'd2, 32'h0BAD_F00D, 1'b0);

        // 6: half-word write to the upper half
        @(negedge clk);
        start_write(32'h0000_0002, 2'd1, 32'hA5A5_0000);
        axi_write(1, 0, 32'h0000_0002, 3'd1, 32'hA5A5_0000, 4'b1100);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Downstream neighbour of the instruction cache and the data-side memory path.
- Converts two sram-like master ports, inst (read-only) and data (read/write), into one AXI3 master with single-beat transfers.
- Sits between the cache layer and the SoC AXI crossbar.
- Arbitrates between the two masters and allows one outstanding transaction in total.

Parameters:
ID_WIDTH, 4, width of the AXI ID fields; inst uses ID 0, data uses ID 1.
ADDR_WIDTH, 32, address width on both sides.

Ports:
clk  in  1  single clock; all logic is on its rising edge.
resetn  in  1  asynchronous, active-low reset.
inst_req  in  1  inst request valid.
inst_addr  in  ADDR_WIDTH  inst byte address.
inst_size  in  2  0 = byte, 1 = half, 2 = word.
inst_rdata  out  32  read data; valid when inst_data_ok = 1.
inst_addr_ok  out  1  inst address accepted this cycle.
inst_data_ok  out  1  inst read complete this cycle.
data_req  in  1  data request valid.
data_wr  in  1  1 = write, 0 = read.
data_size  in  2  encoding as inst_size.
data_addr  in  ADDR_WIDTH  data byte address.
data_wdata  in  32  write data, lane-aligned.
data_rdata  out  32  read data.
data_addr_ok  out  1  data address accepted this cycle.
data_data_ok  out  1  data transaction complete this cycle.
arid  out  ID_WIDTH;  araddr  out  ADDR_WIDTH;  arlen  out  4;  arsize  out  3;  arburst  out  2;  arvalid  out  1;  arready  in  1.
rid  in  ID_WIDTH;  rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.
awid  out  ID_WIDTH;  awaddr  out  ADDR_WIDTH;  awlen  out  4;  awsize  out  3;  awburst  out  2;  awvalid  out  1;  awready  in  1.
wid  out  ID_WIDTH;  wdata  out  32;  wstrb  out  4;  wlast  out  1;  wvalid  out  1;  wready  in  1.
bid  in  ID_WIDTH;  bresp  in  2;  bvalid  in  1;  bready  out  1.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - State goes to IDLE.
  - arvalid, awvalid, wvalid, rready, bready, both addr_ok and both data_ok go to 0.
  - Latched address, size, wdata, owner and the aw/w done flags go to 0.
- State machine: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP.
- IDLE:
  - Grant goes to data if data_req = 1, else to inst if inst_req = 1. Data has fixed priority.
  - The granted master's addr_ok = 1 combinationally in that cycle; the other master's addr_ok = 0.
  - On grant, latch addr, size, wr, wdata and owner.
  - Next state is RD_ADDR for a read, WR for a write.
- RD_ADDR:
  - arvalid = 1; araddr, arsize and arid come from the latches.
  - arlen = 0, arburst = 2'b01, arsize = {1'b0, size}.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid & rlast, pulse the owner's data_ok for exactly that cycle, with owner's rdata = rdata (combinational pass-through). Then go to IDLE.
  - rresp is ignored.
- WR:
  - awvalid and wvalid are both raised on entry.
  - Each handshake independently sets its done flag and drops its valid. aw and w may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
  - wlast = 1, awlen = 0.
  - wstrb by size:
    - size 0: 4'b0001 << addr[1:0].
    - size 1: addr[1] ? 4'b1100 : 4'b0011.
    - size 2 or 3: 4'b1111.
- WR_RESP: bready = 1. On bvalid, pulse data_data_ok for one cycle and go to IDLE.
- Throughput:
  - No new addr_ok is given until the current transaction returns to IDLE.
  - Minimum read latency: grant at cycle 0, arvalid at cycle 1, data_ok at the earliest at cycle 2.
- Inputs may change after addr_ok; only the latched values are used.
- Valids never drop before their handshake completes.
- Reset mid-transaction: aborts immediately and returns to IDLE. The interconnect is reset by the same resetn.
- Unused AXI fields (lock, cache, prot) are handled at the top level.

Decomposition:
- Shared package: AXI burst, size and ID constants (ID_INST = 0, ID_DATA = 1, BURST_INCR), bridge state encoding, and a wstrb function.
- Natural sub-module: sram_axi_arbiter, holding the fixed-priority grant, addr_ok generation and request latches.

Test Plan:
1. inst_req, addr 0xBFC00000, size 2; arready after 2 cycles; rdata 0x3C1D0001 -> araddr = 0xBFC00000, arid = 0; inst_data_ok one cycle with inst_rdata = 0x3C1D0001.
2. inst_req and data_req (read) in the same cycle -> data granted first (arid = 1); inst_addr_ok only after data_data_ok.
3. data write, size 0, addr 0x80000003, wdata 0xAB000000 -> wstrb = 4'b1000, awsize = 0; data_data_ok on bvalid.
4. Write with wready 3 cycles before awready, then the reverse order, then both in the same cycle -> exactly one aw and one w handshake each time, then WR_RESP.
5. resetn dropped while arvalid = 1 -> arvalid is 0 immediately; after release, an inst read completes normally.
6. Half-word write at addr 0x00000002 -> wstrb = 4'b1100.
